// File: rtl/mips_defs_pkg.sv
// Definitions shared between the control unit and the multiply/divide datapath.
package mips_defs;

    localparam int WORD_W = 32;

    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1a;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_DONE = 3'd3,
        MD_DIVZ = 3'd4
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: radix-2 Booth step or restoring-divide step.
module md_step
    import mips_defs::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             div_i,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    // acc carries one guard bit so Booth survives -(-2^(W-1)) and the divide
    // shift never loses the top remainder bit.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = acc_i;
        shifted = '0;
        trial   = '0;
        acc_o   = acc_i;
        q_o     = q_i;
        qm1_o   = qm1_i;
        if (div_i) begin
            shifted = {acc_i[WIDTH-1:0], q_i[WIDTH-1]};
            trial   = shifted - {1'b0, m_i};
            qm1_o   = 1'b0;
            if (trial[WIDTH]) begin
                acc_o = shifted;
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = trial;
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            case ({q_i[0], qm1_i})
                2'b01:   sum = acc_i + {m_i[WIDTH-1], m_i};
                2'b10:   sum = acc_i - {m_i[WIDTH-1], m_i};
                default: sum = acc_i;
            endcase
            acc_o = {sum[WIDTH], sum[WIDTH:1]};
            q_o   = {sum[0], q_i[WIDTH-1:1]};
            qm1_o = q_i[0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit: one iteration per clock, HI/LO written on completion.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int ITERS = WORD_W
) (
    input  logic             clock,
    input  logic             RESET_in,
    input  logic             MultOp,
    input  logic             DivOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Div0,
    output logic             done
);

    localparam int CW = $clog2(ITERS);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             op_mul_q, op_mul_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_q;
    logic             step_qm1;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    md_step #(.WIDTH(WIDTH)) u_step (
        .div_i (state_q == MD_DIV),
        .acc_i (acc_q),
        .q_i   (q_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q),
        .qm1_o (step_qm1)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        op_mul_d = op_mul_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (MultOp) begin
                    state_d  = MD_MULT;
                    op_mul_d = 1'b1;
                    count_d  = '0;
                    acc_d    = '0;
                    q_d      = B;
                    qm1_d    = 1'b0;
                    m_d      = A;
                end else if (DivOp) begin
                    op_mul_d = 1'b0;
                    if (B == '0) begin
                        state_d = MD_DIVZ;
                    end else begin
                        state_d = MD_DIV;
                        count_d = '0;
                        acc_d   = '0;
                        q_d     = a_mag;
                        qm1_d   = 1'b0;
                        m_d     = b_mag;
                        sa_d    = A[WIDTH-1];
                        sb_d    = B[WIDTH-1];
                    end
                end
            end
            MD_MULT, MD_DIV: begin
                if ((state_q == MD_MULT) ? !MultOp : !DivOp) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d   = step_acc;
                    q_d     = step_q;
                    qm1_d   = step_qm1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(ITERS - 1)) begin
                        state_d = MD_DONE;
                        if (state_q == MD_MULT) begin
                            hi_d = step_acc[WIDTH-1:0];
                            lo_d = step_q;
                        end else begin
                            // Truncating division: quotient sign from sa^sb, remainder follows dividend.
                            hi_d = sa_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
                            lo_d = (sa_q ^ sb_q) ? -step_q : step_q;
                        end
                    end
                end
            end
            MD_DONE: begin
                if (op_mul_q ? !MultOp : !DivOp) state_d = MD_IDLE;
            end
            MD_DIVZ: begin
                if (!DivOp) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge RESET_in) begin
        if (!RESET_in) begin
            state_q  <= MD_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            op_mul_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            op_mul_q <= op_mul_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign done = (state_q == MD_DONE);
    assign Div0 = (state_q == MD_DIVZ);

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        RESET_in;
    logic        MultOp, DivOp;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        Div0, done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clock = ~clock;

    mult_div_unit dut (
        .clock    (clock),
        .RESET_in (RESET_in),
        .MultOp   (MultOp),
        .DivOp    (DivOp),
        .A        (A),
        .B        (B),
        .HI       (HI),
        .LO       (LO),
        .Div0     (Div0),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO}: 64-bit product, or {remainder, quotient} with C-style truncation.
    function automatic logic [63:0] ref_result(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (!is_div) begin
            p = sa * sb;
            return p;
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input bit is_div, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] r;
        int n;
        r = ref_result(is_div && !both, a, b);
        @(negedge clock);
        A = a;
        B = b;
        MultOp = !is_div || both;
        DivOp  = is_div || both;
        n = 0;
        do begin
            @(posedge clock);
            n++;
            #1;
            if (n == 1) begin
                A = $urandom;
                B = $urandom;
            end
        end while (!done && n < 40);
        check({tag, "_lat"}, 64'(n), 64'd33);
        check({tag, "_hi"}, 64'(HI), 64'(r[63:32]));
        check({tag, "_lo"}, 64'(LO), 64'(r[31:0]));
        check({tag, "_div0"}, 64'(Div0), 64'd0);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        repeat (3) @(posedge clock);
        #1;
        check({tag, "_hold_done"}, 64'(done), 64'd1);
        check({tag, "_hold_lo"}, 64'(LO), 64'(exp_lo));
        @(negedge clock);
        MultOp = 1'b0;
        DivOp  = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_drop_done"}, 64'(done), 64'd0);
    endtask

    task automatic run_div0(input logic [31:0] a, input string tag);
        @(negedge clock);
        A = a;
        B = '0;
        DivOp = 1'b1;
        @(posedge clock);
        #1;
        check({tag, "_div0"}, 64'(Div0), 64'd1);
        repeat (35) @(posedge clock);
        #1;
        check({tag, "_nodone"}, 64'(done), 64'd0);
        check({tag, "_div0_held"}, 64'(Div0), 64'd1);
        check({tag, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
        @(negedge clock);
        DivOp = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_clr"}, 64'(Div0), 64'd0);
    endtask

    initial begin
        logic [31:0] specials [5];
        logic [31:0] ra, rb;
        bit rdiv;
        specials[0] = 32'h8000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h0000_0001;
        specials[3] = 32'h0000_0000;
        specials[4] = 32'h7FFF_FFFF;

        RESET_in = 1'b0;
        MultOp   = 1'b0;
        DivOp    = 1'b0;
        A        = '0;
        B        = '0;
        #12;
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div0", 64'(Div0), 64'd0);
        @(negedge clock);
        RESET_in = 1'b1;

        run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min");
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
        run_div0(32'd5, "divz");
        run_op(1'b0, 1'b1, 32'd6, 32'd9, "both_req");

        // Abort a multiply after 10 iterations.
        @(negedge clock);
        A = $urandom;
        B = $urandom;
        MultOp = 1'b1;
        repeat (11) @(posedge clock);
        #1;
        check("abort_mid_done", 64'(done), 64'd0);
        @(negedge clock);
        MultOp = 1'b0;
        @(posedge clock);
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {HI, LO}, {exp_hi, exp_lo});
        run_op(1'b0, 1'b0, 32'd3, 32'd4, "mul_3x4");

        // Asynchronous reset in the middle of a divide.
        @(negedge clock);
        A = 32'h1234_5678;
        B = 32'd17;
        DivOp = 1'b1;
        repeat (6) @(posedge clock);
        #2;
        RESET_in = 1'b0;
        #1;
        check("mrst_hilo", {HI, LO}, 64'd0);
        check("mrst_flags", {62'd0, done, Div0}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        DivOp = 1'b0;
        @(negedge clock);
        RESET_in = 1'b1;
        run_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd7, "post_rst_div");

        for (int i = 0; i < 24; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if (rdiv && rb == 32'd0) run_div0(ra, $sformatf("rnd%0d_divz", i));
            else run_op(rdiv, 1'b0, ra, rb, $sformatf("rnd%0d_%s", i, rdiv ? "div" : "mul"));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
